// File: rtl/demux_1to16_seq_pkg.sv
// Shared widths and FSM state encoding for the 1:16 serial-to-parallel demux.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Optional feature macro: DEMUX_PARITY_EN adds the PARITY state.
package demux_pkg;

   localparam int FRAME_W = 16;
   localparam int SLOT_W  = 4;

   // State codes kept as plain constants so legacy code can compare raw bits.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
`ifdef DEMUX_PARITY_EN
   localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COLLECT = ST_COLLECT
`ifdef DEMUX_PARITY_EN
      ,
      PARITY  = ST_PARITY
`endif
   } state_e;

endpackage

// File: rtl/demux_1to16_seq_if.sv
// Serial-in / frame-out bundle for demux_1to16_seq.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the frame consumer; serial side has no ready.
// Ports: master = stream source + frame consumer, slave = the demux itself.
// Optional feature macro: DEMUX_PARITY_EN adds parity_err.
interface demux_1to16_seq_if;
   import demux_pkg::*;

   logic               in_bit;
   logic               in_valid;
   logic               sof;
   logic [SLOT_W-1:0]  select;
   logic [FRAME_W-1:0] out;
   logic               out_valid;
   logic               out_ready;
   logic               overflow;
`ifdef DEMUX_PARITY_EN
   logic               parity_err;
`endif

   modport master (
      output in_bit, in_valid, sof, out_ready,
      input  select, out, out_valid, overflow
`ifdef DEMUX_PARITY_EN
      , input parity_err
`endif
   );

   modport slave (
      input  in_bit, in_valid, sof, out_ready,
      output select, out, out_valid, overflow
`ifdef DEMUX_PARITY_EN
      , output parity_err
`endif
   );

endinterface

// File: rtl/demux_1to16_seq.sv
// Deserializes a 16-slot TDM bit stream into one 16-bit frame (receive side of the 16:1 mux).
// Latency: frame appears on out/out_valid one clock after the last slot (or parity) bit is accepted.
// Backpressure: out held while out_valid && !out_ready; a frame completing then is dropped and overflow sticks until rst.
// Ports: clk, rst (sync, active-high); bus (slave): in_bit/in_valid/sof in, select/out/out_valid/overflow out, out_ready in.
// Optional feature macro: DEMUX_PARITY_EN -- trailing even-parity bit per frame and parity_err output.
module demux_1to16_seq
   import demux_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
)(
   input logic              clk,
   input logic              rst,
   demux_1to16_seq_if.slave bus
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_W - 1);

   state_e             state, state_nxt;
   logic [SLOT_W-1:0]  sel, sel_nxt;
   logic [FRAME_W-1:0] frame, frame_nxt;   // partial frame being assembled
   logic               done;               // a complete frame is offered this cycle
   logic [FRAME_W-1:0] done_word;
   logic [FRAME_W-1:0] out_q;
   logic               out_valid_q;
   logic               overflow_q;
`ifdef DEMUX_PARITY_EN
   logic               done_perr;
   logic               parity_err_q;
`endif

   // Slot-to-bit mapping; slot order reverses when the stream is MSB-first.
   function automatic logic [SLOT_W-1:0] bit_pos(input logic [SLOT_W-1:0] slot);
      return LSB_FIRST ? slot : (LAST_SLOT - slot);
   endfunction

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      frame_nxt = frame;
      done      = 1'b0;
      done_word = frame;
`ifdef DEMUX_PARITY_EN
      done_perr = 1'b0;
`endif
      if (bus.in_valid) begin
         if (bus.sof) begin
            // sof always wins: any partial frame (or pending parity) is thrown away.
            frame_nxt                = '0;
            frame_nxt[bit_pos('0)]   = bus.in_bit;
            sel_nxt                  = SLOT_W'(1);
            state_nxt                = COLLECT;
         end else begin
            case (state)
               COLLECT: begin
                  frame_nxt[bit_pos(sel)] = bus.in_bit;
                  if (sel == LAST_SLOT) begin
                     sel_nxt = '0;
`ifdef DEMUX_PARITY_EN
                     state_nxt = PARITY;
`else
                     done      = 1'b1;
                     done_word = frame_nxt;
                     frame_nxt = '0;
                     state_nxt = IDLE;
`endif
                  end else begin
                     sel_nxt = sel + SLOT_W'(1);
                  end
               end
`ifdef DEMUX_PARITY_EN
               PARITY: begin
                  // Even parity: data ones plus parity bit must total an even count.
                  done      = 1'b1;
                  done_word = frame;
                  done_perr = (^frame) != bus.in_bit;
                  frame_nxt = '0;
                  state_nxt = IDLE;
               end
`endif
               default: begin
                  // IDLE ignores everything but sof.
                  state_nxt = IDLE;
                  sel_nxt   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= '0;
         frame       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         frame <= frame_nxt;
         if (done) begin
            // Slot is free if empty or being drained this very cycle.
            if (!out_valid_q || bus.out_ready) begin
               out_q       <= done_word;
               out_valid_q <= 1'b1;
`ifdef DEMUX_PARITY_EN
               parity_err_q <= done_perr;
`endif
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.select    = sel;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overflow  = overflow_q;
`ifdef DEMUX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: doc/demux_1to16_seq.md
DEMUX_1TO16_SEQ -- requirements
Module: demux_1to16_seq

Interface
REQ-001 Parameter: LSB_FIRST, default 1, slot k drives out[k] when 1 and out[15-k] when 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_bit  input  1  serial data bit for the current slot.
REQ-005 in_valid  input  1  in_bit is valid this cycle; bit accepted when high.
REQ-006 sof  input  1  start of frame; qualifies the accepted bit as slot 0.
REQ-007 select  output  4  current slot index, the slot the next accepted bit fills.
REQ-008 out  output  16  assembled frame, held stable while out_valid is high.
REQ-009 out_valid  output  1  frame available on out.
REQ-010 out_ready  input  1  consumer accepts frame when out_valid && out_ready.
REQ-011 overflow  output  1  sticky flag for a completed frame that was dropped.
REQ-012 parity_err  output  1  parity mismatch for the frame on out; present only with DEMUX_PARITY_EN.

Function
REQ-013 The block SHALL be the receive-side counterpart of the 16:1 mux: it deserializes a 16-slot time-division stream into one 16-bit word.
REQ-014 The FSM SHALL have states IDLE, COLLECT, and PARITY (PARITY only with the macro).
REQ-015 IDLE: when in_valid && sof, store in_bit in slot 0, set select=1, go to COLLECT; all other inputs are ignored and select=0.
REQ-016 COLLECT: each in_valid cycle stores in_bit in slot select and increments select; when in_valid is low, the slot and data hold (stall).
REQ-017 When in_valid && sof in COLLECT, the partial frame SHALL be discarded and collection restarts with this bit as slot 0 (select=1); overflow is not set.
REQ-018 When slot 15 is accepted (no macro), the frame completes; the state returns to IDLE and select wraps to 0.
REQ-019 Completion SHALL load out and set out_valid on the next rising edge (1-cycle latency after the slot-15 bit).
REQ-020 If out_valid is high and out_ready is low at completion, the new frame SHALL be dropped, out is unchanged, and overflow is set to 1.
REQ-021 If completion and out_valid && out_ready occur in the same cycle, the new frame SHALL load, out_valid stays high, and overflow is unchanged.
REQ-022 out_valid SHALL clear on out_valid && out_ready with no simultaneous completion.
REQ-023 sof with in_valid in the completing cycle is treated as slot 0 of a new frame (back-to-back frames with no idle cycle).

Reset
REQ-024 On rst: state=IDLE, select=0, out=16'h0000, out_valid=0, overflow=0, parity_err=0, and the partial frame is cleared.
REQ-025 rst mid-frame SHALL discard all collected bits; overflow clears only on rst.

Configuration
REQ-026 With DEMUX_PARITY_EN defined: after slot 15 the FSM enters PARITY; the next accepted bit is an even-parity bit over the 16 data bits; completion occurs on that bit; parity_err loads with out and is 1 on mismatch; the frame is delivered regardless; sof in PARITY restarts as in REQ-017.
REQ-027 Without DEMUX_PARITY_EN: there is no PARITY state and no parity_err port; frames are 16 slots.

Structure
REQ-028 Package demux_pkg SHALL hold FRAME_W=16, SLOT_W=4, and the FSM state enum.
REQ-029 The design is a single module; no sub-module is required.

Verification
REQ-030 Serialize 16'hA5C3 LSB-first with sof on slot 0 and out_ready=1 -> out=16'hA5C3 and out_valid high 1 cycle after slot 15.
REQ-031 Send the same frame with in_valid deasserted for 3 cycles at slot 7 -> select holds 7 and out=16'hA5C3 is still produced.
REQ-032 Hold out_ready=0 and send two frames 16'h1234 then 16'h5678 -> out stays 16'h1234 and overflow=1 until rst.
REQ-033 Assert sof at slot 9 of a partial frame, then send 16'hFFFF -> out=16'hFFFF with no partial data and overflow=0.
REQ-034 Send back-to-back frames 16'h0001 and 16'h8000 with out_ready=1 and no gap -> two consecutive out_valid frames with the correct values.
REQ-035 With DEMUX_PARITY_EN, send 16'h0003 with parity bit 1 -> parity_err=1 and out=16'h0003; with parity bit 0 -> parity_err=0.
